gshare_pht: RTL and testbench
=============================

// Module: gshare_pht
// PURPOSE
//  Direction predictor for the BP stage: gshare pattern history table (2-bit saturating counters) plus global history
//  register (GHR). Looked up in parallel with the BTB on the fetch PC; its taken bit qualifies the BTB hit into a
//  redirect. Trained and repaired by branch resolution (ID/EX). PHT index and GHR snapshot travel down the pipe for update.
// PARAMETERS
//  GHR_WIDTH   8            history bits; PHT index width
//  PHT_SIZE    2**GHR_WIDTH number of 2-bit counters
//  CNT_INIT    2'b01        counter value after reset (weakly not-taken)
// PORTS
//  clk              in   1          clock; all state updates on posedge
//  rst              in   1          synchronous reset, active-low
//  lookup_en        in   1          fetch PC valid and fetch not stalled this cycle
//  pc_in            in   ADDR_BUS   fetch PC (same PC as fed to BTB)
//  btb_hit_in       in   1          BTB is_branch_out for pc_in
//  btb_is_jump_in   in   1          BTB is_jump_out for pc_in
//  pred_taken_out   out  1          final prediction: hit && (jump || counter[1])
//  pred_index_out   out  GHR_WIDTH  PHT index used for this lookup
//  pred_ghr_out     out  GHR_WIDTH  GHR value before this lookup's speculative shift (checkpoint)
//  update_en        in   1          resolved conditional branch this cycle
//  update_index     in   GHR_WIDTH  pred_index_out carried with that branch
//  update_ghr       in   GHR_WIDTH  pred_ghr_out carried with that branch
//  update_taken     in   1          actual direction
//  update_mispredict in  1          actual direction != predicted direction (qualified by update_en)
// BEHAVIOUR
//  - Index: pred_index_out = pc_in[GHR_WIDTH+1:2] ^ ghr. Lookup is combinational, zero latency, same cycle as BTB.
//  - pred_taken_out = btb_hit_in && (btb_is_jump_in || pht[index][1]); 0 when lookup_en=0. Other outputs free-running.
//  - Speculative GHR: on posedge with lookup_en && btb_hit_in && !btb_is_jump_in: ghr <= {ghr[W-2:0], pred_taken_out}.
//    Jumps and BTB misses do not shift.
//  - Repair: update_en && update_mispredict: ghr <= {update_ghr[W-2:0], update_taken}. Repair has priority over a
//    simultaneous speculative shift (the lookup that cycle is on the wrong path and is discarded).
//  - Training: update_en: pht[update_index] <= sat(pht[update_index], update_taken); +1 saturating at 2'b11 when taken,
//    -1 saturating at 2'b00 when not taken. Trains on every resolution, mispredicted or not.
//  - Read/write same index same cycle: lookup sees OLD counter value (no bypass); write lands at the edge.
//  - Wrap-around: index is pure XOR in GHR_WIDTH bits; PC bits above GHR_WIDTH+1 ignored (aliasing accepted).
//  - Reset (rst=0 at posedge): ghr <= 0, all counters <= CNT_INIT; reset wins over update and lookup. Outputs after
//    reset: pred_taken_out=0 unless btb_hit_in && btb_is_jump_in; pred_ghr_out=0; pred_index_out=pc_in[W+1:2].
//  - Reset asserted mid-operation discards all history; no pending state survives.
//  - update_mispredict without update_en: ignored entirely.
// STRUCTURE
//  - branch.v gains: `GHR_WIDTH, `PHT_SIZE, `PHT_INDEX_BUS, `PHT_CNT_BUS, `PHT_CNT_INIT, counter encodings
//    (SNT=00, WNT=01, WT=10, ST=11). Ports use `ADDR_BUS from bus.v.
//  - One sub-module: pht_sat_counter (2-bit counter cell: clk, rst, write_en, taken_in, cnt_out), generated PHT_SIZE
//    times with one-hot write enable from update_index, mirroring the BTB line array. GHR and muxing in top.
// TESTING
//  1 Reset: hold rst=0 2 cycles, release; btb_hit_in=1, jump=0, any pc -> pred_taken_out=0, pred_ghr_out=0.
//  2 Training: update_en, index 0x12, taken=1, twice -> cnt 01->10->11; lookup PC mapping to 0x12 with hit ->
//    pred_taken_out=1; three not-taken updates -> 11->10->01->00, further not-taken stays 00.
//  3 GHR shift: 3 consecutive hit conditional lookups predicted T,N,T from ghr=0 -> ghr=0x05; jump hit and BTB miss
//    cycles leave ghr unchanged; lookup_en=0 leaves it unchanged.
//  4 Repair priority: ghr=0x05, same cycle speculative shift + update_mispredict with update_ghr=0x80, taken=1 ->
//    next ghr=0x01 (repair wins, MSB shifted out).
//  5 Same-index collision: cnt[0x34]=01, lookup and taken update to 0x34 same cycle -> pred_taken_out=0 that cycle,
//    =1 next cycle for same index.
//  6 Reset mid-stream: after training entries to 11 and ghr=0xAA, pulse rst=0 one cycle concurrent with update_en ->
//    all counters 01, ghr 0, the concurrent update lost.

Source files
------------

// File: rtl/gshare_pht_pkg.sv
// gshare_pht_pkg: shared sizes, counter encodings and saturating-update helper for the gshare predictor
package gshare_pht_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int GHR_WIDTH = 8;
  localparam int PHT_SIZE = 2 ** GHR_WIDTH;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_e;
  localparam cnt_e CNT_INIT = WNT;
  function automatic cnt_e sat_next(cnt_e c, logic taken);
    return taken ? (c == ST ? ST : cnt_e'(c + 2'd1)) : (c == SNT ? SNT : cnt_e'(c - 2'd1));
  endfunction
endpackage

// File: rtl/gshare_pht_sat_counter.sv
// gshare_pht_sat_counter: one 2-bit saturating PHT cell
//   clk, rst (sync, active-low) | write_en_i, taken_i: train this cell | cnt_o: current counter
module gshare_pht_sat_counter
  import gshare_pht_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       write_en_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);
  cnt_e cnt_q, cnt_d;
  always_comb cnt_d = write_en_i ? sat_next(cnt_q, taken_i) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst ? CNT_INIT : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/gshare_pht.sv
// gshare_pht: gshare direction predictor (PHT of 2-bit counters + speculative global history)
//   clk, rst (sync, active-low)
//   lookup_en_i, pc_i, btb_hit_i, btb_is_jump_i -> pred_taken_o, pred_index_o, pred_ghr_o (combinational lookup)
//   update_en_i, update_index_i, update_ghr_i, update_taken_i, update_mispredict_i: resolution train/repair
module gshare_pht
  import gshare_pht_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_en_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  btb_hit_i,
  input  logic                  btb_is_jump_i,
  output logic                  pred_taken_o,
  output logic [GHR_WIDTH-1:0]  pred_index_o,
  output logic [GHR_WIDTH-1:0]  pred_ghr_o,
  input  logic                  update_en_i,
  input  logic [GHR_WIDTH-1:0]  update_index_i,
  input  logic [GHR_WIDTH-1:0]  update_ghr_i,
  input  logic                  update_taken_i,
  input  logic                  update_mispredict_i
);
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic [1:0] cnt [PHT_SIZE];
  logic unused_pc;
  // PC bits outside the index window are deliberately ignored (aliasing accepted)
  assign unused_pc = ^{pc_i[ADDR_WIDTH-1:GHR_WIDTH+2], pc_i[1:0]};
  for (genvar i = 0; i < PHT_SIZE; i++) begin : g_pht
    gshare_pht_sat_counter u_cnt (
      .clk(clk),
      .rst(rst),
      .write_en_i(update_en_i && update_index_i == GHR_WIDTH'(i)),
      .taken_i(update_taken_i),
      .cnt_o(cnt[i])
    );
  end
  assign pred_index_o = pc_i[GHR_WIDTH+1:2] ^ ghr_q;
  assign pred_ghr_o = ghr_q;
  // reads the pre-edge counter, so a same-cycle update to this index is not bypassed
  assign pred_taken_o = lookup_en_i && btb_hit_i && (btb_is_jump_i || cnt[pred_index_o][1]);
  // repair beats the speculative shift: that cycle's lookup is on the wrong path
  always_comb
    ghr_d = (update_en_i && update_mispredict_i) ? {update_ghr_i[GHR_WIDTH-2:0], update_taken_i}
          : (lookup_en_i && btb_hit_i && !btb_is_jump_i) ? {ghr_q[GHR_WIDTH-2:0], pred_taken_o}
          : ghr_q;
  always_ff @(posedge clk) ghr_q <= !rst ? '0 : ghr_d;
endmodule

// File: tb/tb_gshare_pht.sv
// tb_gshare_pht: directed self-checking bench for gshare_pht
module tb_gshare_pht;
  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] pc;
  logic        btb_hit;
  logic        btb_is_jump;
  logic        pred_taken;
  logic [7:0]  pred_index;
  logic [7:0]  pred_ghr;
  logic        update_en;
  logic [7:0]  update_index;
  logic [7:0]  update_ghr;
  logic        update_taken;
  logic        update_mispredict;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  gshare_pht dut (
    .clk(clk),
    .rst(rst),
    .lookup_en_i(lookup_en),
    .pc_i(pc),
    .btb_hit_i(btb_hit),
    .btb_is_jump_i(btb_is_jump),
    .pred_taken_o(pred_taken),
    .pred_index_o(pred_index),
    .pred_ghr_o(pred_ghr),
    .update_en_i(update_en),
    .update_index_i(update_index),
    .update_ghr_i(update_ghr),
    .update_taken_i(update_taken),
    .update_mispredict_i(update_mispredict)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic lk(input logic [31:0] p, input logic hit, input logic jmp);
    lookup_en = 1'b1;
    pc = p;
    btb_hit = hit;
    btb_is_jump = jmp;
    #1;
  endtask
  task automatic idle();
    lookup_en = 1'b0;
    btb_hit = 1'b0;
    btb_is_jump = 1'b0;
  endtask
  task automatic upd(input logic [7:0] idx, input logic t);
    update_en = 1'b1;
    update_index = idx;
    update_taken = t;
    update_mispredict = 1'b0;
  endtask
  task automatic probe(input string tag, input logic [31:0] p, input logic [7:0] exp_idx, input logic exp_t);
    lk(p, 1'b1, 1'b0);
    chk({tag, "_idx"}, pred_index, exp_idx);
    chk({tag, "_taken"}, pred_taken, exp_t);
    idle();
  endtask
  initial begin
    rst = 1'b0;
    idle();
    pc = '0;
    update_en = 1'b0;
    update_index = '0;
    update_ghr = '0;
    update_taken = 1'b0;
    update_mispredict = 1'b0;
    step();
    step();
    lk(32'h48, 1'b1, 1'b0);
    chk("rst_taken", pred_taken, 0);
    chk("rst_ghr", pred_ghr, 0);
    chk("rst_idx", pred_index, 8'h12);
    btb_is_jump = 1'b1;
    #1;
    chk("rst_jump_taken", pred_taken, 1);
    idle();
    rst = 1'b1;
    step();
    upd(8'h12, 1'b1);
    step();
    step();
    step();
    update_en = 1'b0;
    probe("train_st", 32'h48, 8'h12, 1'b1);
    upd(8'h12, 1'b0);
    step();
    update_en = 1'b0;
    probe("train_wt", 32'h48, 8'h12, 1'b1);
    upd(8'h12, 1'b0);
    step();
    update_en = 1'b0;
    probe("train_wnt", 32'h48, 8'h12, 1'b0);
    upd(8'h12, 1'b0);
    step();
    step();
    upd(8'h12, 1'b1);
    step();
    update_en = 1'b0;
    probe("train_floor", 32'h48, 8'h12, 1'b0);
    chk("ghr_still0", pred_ghr, 0);
    upd(8'h40, 1'b1);
    step();
    step();
    update_en = 1'b0;
    lk(32'h100, 1'b1, 1'b0);
    chk("shift1_taken", pred_taken, 1);
    step();
    chk("shift1_ghr", pred_ghr, 8'h01);
    lk(32'h80, 1'b1, 1'b0);
    chk("shift2_idx", pred_index, 8'h21);
    chk("shift2_taken", pred_taken, 0);
    step();
    chk("shift2_ghr", pred_ghr, 8'h02);
    lk(32'h108, 1'b1, 1'b0);
    chk("shift3_idx", pred_index, 8'h40);
    chk("shift3_taken", pred_taken, 1);
    step();
    chk("shift3_ghr", pred_ghr, 8'h05);
    lk(32'h108, 1'b1, 1'b1);
    chk("jump_taken", pred_taken, 1);
    step();
    chk("jump_ghr", pred_ghr, 8'h05);
    lk(32'h108, 1'b0, 1'b0);
    chk("miss_taken", pred_taken, 0);
    step();
    chk("miss_ghr", pred_ghr, 8'h05);
    lk(32'h108, 1'b1, 1'b0);
    lookup_en = 1'b0;
    #1;
    chk("noen_taken", pred_taken, 0);
    step();
    chk("noen_ghr", pred_ghr, 8'h05);
    lk(32'h108, 1'b1, 1'b0);
    upd(8'h77, 1'b1);
    update_mispredict = 1'b1;
    update_ghr = 8'h80;
    step();
    idle();
    update_en = 1'b0;
    chk("repair_ghr", pred_ghr, 8'h01);
    update_ghr = 8'hF0;
    step();
    update_mispredict = 1'b0;
    chk("mispred_no_en_ghr", pred_ghr, 8'h01);
    lk(32'hD4, 1'b1, 1'b0);
    upd(8'h34, 1'b1);
    #1;
    chk("coll_idx", pred_index, 8'h34);
    chk("coll_old", pred_taken, 0);
    step();
    update_en = 1'b0;
    chk("coll_ghr", pred_ghr, 8'h02);
    lk(32'hD8, 1'b1, 1'b0);
    chk("coll_new_idx", pred_index, 8'h34);
    chk("coll_new", pred_taken, 1);
    idle();
    upd(8'h12, 1'b1);
    step();
    step();
    upd(8'h34, 1'b1);
    step();
    upd(8'h77, 1'b0);
    update_mispredict = 1'b1;
    update_ghr = 8'h55;
    step();
    update_en = 1'b0;
    update_mispredict = 1'b0;
    chk("pre_rst_ghr", pred_ghr, 8'hAA);
    probe("pre_rst_12", 32'h2E0, 8'h12, 1'b1);
    upd(8'h50, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    update_en = 1'b0;
    chk("mid_rst_ghr", pred_ghr, 0);
    probe("mid_rst_12", 32'h48, 8'h12, 1'b0);
    probe("mid_rst_34", 32'hD0, 8'h34, 1'b0);
    probe("mid_rst_50", 32'h140, 8'h50, 1'b0);
    probe("mid_rst_alias", 32'hFFFF_F048, 8'h12, 1'b0);
    upd(8'h12, 1'b1);
    step();
    update_en = 1'b0;
    probe("post_rst_init", 32'h48, 8'h12, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
